// File: rtl/lsu_pkg.sv
// Shared types and encodings for the MEM-stage load/store controller.
// EXT_* opcodes are also decoded by the downstream load-extension unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [2:0] EXT_WORD   = 3'b000;
   localparam logic [2:0] EXT_BYTE_U = 3'b001;
   localparam logic [2:0] EXT_BYTE_S = 3'b010;
   localparam logic [2:0] EXT_HALF_U = 3'b011;
   localparam logic [2:0] EXT_HALF_S = 3'b100;

   // Size 2'b11 falls into the word encoding.
   function automatic logic [2:0] ext_op_f(input logic [1:0] size, input logic sgn);
      case (size)
         SZ_BYTE: return sgn ? EXT_BYTE_S : EXT_BYTE_U;
         SZ_HALF: return sgn ? EXT_HALF_S : EXT_HALF_U;
         default: return EXT_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline-side and data-bus-side signals of lsu_ctrl.
// slave = controller view, master = pipeline + bus environment view.
interface lsu_ctrl_if;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic [1:0]  ld_a;
   logic [2:0]  ld_ext_op;
   logic        exc_adel;
   logic        exc_ades;
   logic        exc_bus;

   modport slave (
      input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, flush,
      input  mem_ack, mem_rdata,
      output stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output ld_valid, ld_data, ld_a, ld_ext_op, exc_adel, exc_ades, exc_bus
   );

   modport master (
      output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, flush,
      output mem_ack, mem_rdata,
      input  stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  ld_valid, ld_data, ld_a, ld_ext_op, exc_adel, exc_ades, exc_bus
   );
endinterface

// File: rtl/lsu_store_align.sv
// Store lane steering: byte enables, lane-replicated write data and
// the misaligned flag, purely combinational from size and addr[1:0].
module lsu_store_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        mis_o
);

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      mis_o   = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         SZ_HALF: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            mis_o   = addr_lo_i[0];
         end
         default: begin
            mis_o = |addr_lo_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: one req/ack bus transaction at a time.
// Optional bus watchdog enabled with `define LSU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an aligned, unflushed request; exceptions reported here
// REQ   | mem_req held with stable address/data until mem_ack
// DONE  | one cycle: load result presented, pipeline released
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_W = 8
) (
   input logic       clk,
   input logic       rst_n,
   lsu_ctrl_if.slave lsu
);

   lsu_state_e  state_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;
   logic        ld_valid_q;
   logic [31:0] ld_data_q;
   logic [1:0]  ld_a_q;
   logic [2:0]  ld_ext_op_q;
   logic        abort_q;

   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic        mis_c;
   logic        idle_c;
   logic        accept_c;

   lsu_store_align u_align (
      .size_i    (lsu.req_size),
      .addr_lo_i (lsu.req_addr[1:0]),
      .wdata_i   (lsu.req_wdata),
      .be_o      (be_c),
      .wdata_o   (wdata_c),
      .mis_o     (mis_c)
   );

   assign idle_c   = (state_q == IDLE);
   assign accept_c = idle_c & lsu.req_valid & ~mis_c & ~lsu.flush;

`ifdef LSU_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   logic [TIMEOUT_W-1:0] to_cnt_q;
   logic                 exc_bus_q;
`else
   logic [TIMEOUT_W-1:0] unused_to_cnt;
   assign unused_to_cnt = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         ld_valid_q  <= 1'b0;
         ld_data_q   <= '0;
         ld_a_q      <= '0;
         ld_ext_op_q <= '0;
         abort_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         to_cnt_q    <= '0;
         exc_bus_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  state_q     <= REQ;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= lsu.req_we;
                  mem_addr_q  <= {lsu.req_addr[31:2], 2'b00};
                  mem_be_q    <= lsu.req_we ? be_c : 4'b0000;
                  mem_wdata_q <= wdata_c;
                  ld_a_q      <= lsu.req_addr[1:0];
                  ld_ext_op_q <= ext_op_f(lsu.req_size, lsu.req_sign);
                  abort_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                  to_cnt_q    <= '0;
`endif
               end
            end
            REQ: begin
               if (lsu.flush) abort_q <= 1'b1;
               // A flush coinciding with the ack must already suppress the result.
               if (lsu.mem_ack) begin
                  state_q    <= DONE;
                  mem_req_q  <= 1'b0;
                  ld_data_q  <= lsu.mem_rdata;
                  ld_valid_q <= ~mem_we_q & ~abort_q & ~lsu.flush;
               end
`ifdef LSU_TIMEOUT_EN
               else if (to_cnt_q == TO_LAST) begin
                  state_q    <= DONE;
                  mem_req_q  <= 1'b0;
                  ld_valid_q <= 1'b0;
                  exc_bus_q  <= 1'b1;
                  to_cnt_q   <= to_cnt_q + TIMEOUT_W'(1);
               end else begin
                  to_cnt_q   <= to_cnt_q + TIMEOUT_W'(1);
               end
`endif
            end
            DONE: begin
               state_q    <= IDLE;
               ld_valid_q <= 1'b0;
               abort_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
               exc_bus_q  <= 1'b0;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lsu.stall     = accept_c | (state_q == REQ);
   assign lsu.mem_req   = mem_req_q;
   assign lsu.mem_we    = mem_we_q;
   assign lsu.mem_addr  = mem_addr_q;
   assign lsu.mem_be    = mem_be_q;
   assign lsu.mem_wdata = mem_wdata_q;
   assign lsu.ld_valid  = ld_valid_q;
   assign lsu.ld_data   = ld_data_q;
   assign lsu.ld_a      = ld_a_q;
   assign lsu.ld_ext_op = ld_ext_op_q;
   assign lsu.exc_adel  = idle_c & lsu.req_valid & ~lsu.req_we & mis_c;
   assign lsu.exc_ades  = idle_c & lsu.req_valid & lsu.req_we & mis_c;
`ifdef LSU_TIMEOUT_EN
   assign lsu.exc_bus   = exc_bus_q;
`else
   assign lsu.exc_bus   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (default build, watchdog disabled).
module tb_lsu_ctrl;
   import lsu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   req_cycles;

   lsu_ctrl_if lsu ();

   lsu_ctrl #(.TIMEOUT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .lsu   (lsu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      lsu.req_valid = 1'b0;
      lsu.req_we    = 1'b0;
      lsu.req_size  = SZ_WORD;
      lsu.req_sign  = 1'b0;
      lsu.req_addr  = '0;
      lsu.req_wdata = '0;
      lsu.flush     = 1'b0;
      lsu.mem_ack   = 1'b0;
      lsu.mem_rdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Full aligned access; ack arrives after 'waits' extra REQ cycles.
   task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits, input logic fl,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic [2:0] exp_ext);
      next_cycle();
      lsu.req_valid = 1'b1;
      lsu.req_we    = we;
      lsu.req_size  = size;
      lsu.req_sign  = sgn;
      lsu.req_addr  = addr;
      lsu.req_wdata = wdata;
      @(negedge clk);
      check({tag, " c0 stall"}, 32'(lsu.stall), 32'd1);
      check({tag, " c0 mem_req"}, 32'(lsu.mem_req), 32'd0);
      req_cycles = 0;
      for (int i = 0; i <= waits; i++) begin
         next_cycle();
         lsu.mem_ack   = (i == waits);
         lsu.mem_rdata = (i == waits) ? rdata : 32'hBAD0_BAD0;
         lsu.flush     = fl && (i == 0);
         @(negedge clk);
         if (lsu.mem_req) req_cycles++;
         check({tag, " req stall"}, 32'(lsu.stall), 32'd1);
         check({tag, " mem_addr"}, lsu.mem_addr, {addr[31:2], 2'b00});
         check({tag, " mem_be"}, 32'(lsu.mem_be), 32'(exp_be));
         check({tag, " mem_we"}, 32'(lsu.mem_we), 32'(we));
         if (we) check({tag, " mem_wdata"}, lsu.mem_wdata, exp_wd);
         check({tag, " req ld_valid"}, 32'(lsu.ld_valid), 32'd0);
      end
      check({tag, " req cycles"}, 32'(req_cycles), 32'(waits + 1));
      next_cycle();
      lsu.mem_ack = 1'b0;
      lsu.flush   = 1'b0;
      @(negedge clk);
      check({tag, " done mem_req"}, 32'(lsu.mem_req), 32'd0);
      check({tag, " done stall"}, 32'(lsu.stall), 32'd0);
      check({tag, " done ld_valid"}, 32'(lsu.ld_valid), 32'(!we && !fl));
      if (!we) begin
         check({tag, " ld_data"}, lsu.ld_data, rdata);
         check({tag, " ld_ext_op"}, 32'(lsu.ld_ext_op), 32'(exp_ext));
         check({tag, " ld_a"}, 32'(lsu.ld_a), 32'(addr[1:0]));
      end
      next_cycle();
      lsu.req_valid = 1'b0;
      @(negedge clk);
      check({tag, " after ld_valid"}, 32'(lsu.ld_valid), 32'd0);
      check({tag, " after stall"}, 32'(lsu.stall), 32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      drive_idle();
      @(negedge clk);
      check("rst mem_req", 32'(lsu.mem_req), 32'd0);
      check("rst mem_be", 32'(lsu.mem_be), 32'd0);
      check("rst mem_addr", lsu.mem_addr, 32'd0);
      check("rst mem_wdata", lsu.mem_wdata, 32'd0);
      check("rst ld_valid", 32'(lsu.ld_valid), 32'd0);
      check("rst ld_data", lsu.ld_data, 32'd0);
      check("rst ld_ext_op", 32'(lsu.ld_ext_op), 32'd0);
      check("rst exc_bus", 32'(lsu.exc_bus), 32'd0);
      next_cycle();
      rst_n = 1'b1;

      do_access("lw", 1'b0, SZ_WORD, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0,
                4'b0000, 32'h0, EXT_WORD);
      do_access("sb", 1'b1, SZ_BYTE, 1'b0, 32'h0000_2003, 32'h0000_00A5, 32'h0, 3, 1'b0,
                4'b1000, 32'hA5A5_A5A5, EXT_BYTE_U);
      do_access("sh", 1'b1, SZ_HALF, 1'b0, 32'h0000_2002, 32'h0000_1234, 32'h0, 1, 1'b0,
                4'b1100, 32'h1234_1234, EXT_HALF_U);
      do_access("lh_s", 1'b0, SZ_HALF, 1'b1, 32'h0000_5002, 32'h0, 32'h8001_7FFE, 2, 1'b0,
                4'b0000, 32'h0, EXT_HALF_S);
      do_access("lb_s", 1'b0, SZ_BYTE, 1'b1, 32'h0000_5001, 32'h0, 32'h0000_8000, 0, 1'b0,
                4'b0000, 32'h0, EXT_BYTE_S);

      // Misaligned accesses raise exceptions and never touch the bus.
      next_cycle();
      lsu.req_valid = 1'b1; lsu.req_we = 1'b0; lsu.req_size = SZ_HALF; lsu.req_addr = 32'h3001;
      @(negedge clk);
      check("lh mis exc_adel", 32'(lsu.exc_adel), 32'd1);
      check("lh mis exc_ades", 32'(lsu.exc_ades), 32'd0);
      check("lh mis stall", 32'(lsu.stall), 32'd0);
      next_cycle();
      lsu.req_we = 1'b1; lsu.req_size = SZ_WORD; lsu.req_addr = 32'h3002;
      @(negedge clk);
      check("lh mis no req", 32'(lsu.mem_req), 32'd0);
      check("sw mis exc_ades", 32'(lsu.exc_ades), 32'd1);
      check("sw mis exc_adel", 32'(lsu.exc_adel), 32'd0);
      check("sw mis stall", 32'(lsu.stall), 32'd0);
      next_cycle();
      drive_idle();
      @(negedge clk);
      check("sw mis no req", 32'(lsu.mem_req), 32'd0);

      // Flush in first REQ cycle: bus completes, result suppressed.
      do_access("lbu_fl", 1'b0, SZ_BYTE, 1'b0, 32'h0000_4002, 32'h0, 32'h1122_3344, 1, 1'b1,
                4'b0000, 32'h0, EXT_BYTE_U);
      do_access("lw_post", 1'b0, SZ_WORD, 1'b0, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 0, 1'b0,
                4'b0000, 32'h0, EXT_WORD);

      // Stray ack while idle is ignored.
      next_cycle();
      lsu.mem_ack = 1'b1; lsu.mem_rdata = 32'h5555_5555;
      @(negedge clk);
      check("stray ack mem_req", 32'(lsu.mem_req), 32'd0);
      next_cycle();
      lsu.mem_ack = 1'b0;
      @(negedge clk);
      check("stray ack ld_valid", 32'(lsu.ld_valid), 32'd0);
      check("stray ack ld_data", lsu.ld_data, 32'hCAFE_F00D);

      // Asynchronous reset in the middle of REQ.
      next_cycle();
      lsu.req_valid = 1'b1; lsu.req_we = 1'b0; lsu.req_size = SZ_WORD; lsu.req_addr = 32'h6000;
      next_cycle();
      @(negedge clk);
      check("mid rst pre mem_req", 32'(lsu.mem_req), 32'd1);
      #1;
      rst_n = 1'b0;
      lsu.req_valid = 1'b0;
      #1;
      check("mid rst mem_req", 32'(lsu.mem_req), 32'd0);
      check("mid rst stall", 32'(lsu.stall), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      lsu.mem_ack = 1'b1; lsu.mem_rdata = 32'h7777_7777;
      @(negedge clk);
      check("post rst mem_req", 32'(lsu.mem_req), 32'd0);
      next_cycle();
      lsu.mem_ack = 1'b0;
      @(negedge clk);
      check("post rst ld_valid", 32'(lsu.ld_valid), 32'd0);
      check("post rst ld_data", lsu.ld_data, 32'd0);

      do_access("lhu_rec", 1'b0, SZ_HALF, 1'b0, 32'h0000_7002, 32'h0, 32'h0BAD_F00D, 0, 1'b0,
                4'b0000, 32'h0, EXT_HALF_U);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
